score_ram: RTL and testbench
============================

# score_ram

Storage-side responder for the per-user level/score protocol: it accepts the address, read/write strobe and write data driven by the RAM controller, and returns read data on the controller's input bus. It holds one 8-bit level per user slot and clears itself after reset. It also tracks the highest level ever written so the display path can show a best score. It sits directly between the RAM controller and the score/level display logic.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, 2..256.
- WIDTH, 8, entry width in bits.

Ports:
- clk  input  1  on-board 50 MHz clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address_in  input  8  entry address from the controller; only values < DEPTH are in range.
- r_w  input  1  access type: 1 = write, 0 = read; sampled every cycle.
- data_in  input  WIDTH  write data (the controller's data_out).
- data_out  output  WIDTH  registered read data (the controller's data_in).
- ready  output  1  high once the post-reset clear sweep is complete.
- best_level  output  WIDTH  highest value written since reset.
- best_addr  output  8  address of the entry that produced best_level.

## Operation
- Reset (reset=1 at a clk edge): state := CLEAR, clr_ptr := 0, data_out := 0, ready := 0, best_level := 0, best_addr := 0. Reset overrides all other activity, including a sweep already in progress; the sweep restarts from entry 0.
- CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. When clr_ptr == DEPTH-1 is written, state := RUN and ready := 1. Bus inputs are ignored in CLEAR: no writes, data_out holds 0, and the tracker does not update.
- RUN: every cycle is one access; there is no separate valid strobe.
  - r_w=1, address_in < DEPTH: mem[address_in] := data_in; data_out := data_in (write-through).
  - r_w=1, address_in ≥ DEPTH: write dropped; data_out := 0.
  - r_w=0, address_in < DEPTH: data_out := mem[address_in].
  - r_w=0, address_in ≥ DEPTH: data_out := 0.
- Best tracker (applies to accepted RUN writes only): if data_in > best_level (unsigned), then best_level := data_in and best_addr := address_in.
  - A tie keeps the earlier address.
  - Overwriting the best entry with a lower value does not lower best_level; it is a historical maximum.
- Width rules: all comparisons are unsigned. Values are stored unmodified, with no saturation or wrap.

## Timing
- Read latency is 1 cycle: an address presented at edge N appears on data_out after edge N+1.
- Write followed by a read of the same address on the next cycle returns the new value; there is no hazard window.
- Back-to-back writes to the same address: the last one wins.
- ready rises after exactly DEPTH edges with reset=0 following reset release, and stays high until the next reset.
- best_level and best_addr update on the same edge as the accepted write.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SCORE_RAM_BEST_EN defined: the best tracker is compiled in as described above.
- Not defined: the tracker logic is removed, and best_level and best_addr are tied to 0 permanently. Storage, clear sweep, read and write behaviour are identical in both builds.

## Test plan
- Reset release with DEPTH=16 -> ready=0 for 16 cycles, then 1. A read of every address returns 0. A write of 8'h55 issued during CLEAR is not stored.
- RUN: write 8'h03 to address 1, then read address 1 the next cycle -> data_out = 8'h03 one cycle after the read. A read of address 0 returns 0.
- Write 8'h07 to address 20 (out of range), then read address 20 -> data_out = 0 and no entry is modified (read all 16 entries back).
- Writes 5@addr2, 9@addr3, 9@addr0, 4@addr3 -> best_level=9 and best_addr=3 after each of the last three writes, with only the SCORE_RAM_BEST_EN build. The non-EN build shows 0/0 throughout.
- Assert reset for 1 cycle at clr_ptr=7 mid-sweep, then deassert -> ready rises exactly 16 cycles after deassertion and all entries read back 0.
- Assert reset in RUN after data is stored -> the next cycle shows data_out=0, ready=0 and best_level=0; after the sweep completes, previously stored entries read 0.

Source files
------------

// File: rtl/score_ram_if.sv
// score_ram_if: controller-to-score-RAM bus, carrying address, write strobe, write data, read data and best-score status.
interface score_ram_if #(parameter int WIDTH = 8);
  logic [7:0] address_in;
  logic r_w;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic ready;
  logic [WIDTH-1:0] best_level;
  logic [7:0] best_addr;
  modport master (output address_in, r_w, data_in, input data_out, ready, best_level, best_addr);
  modport slave (input address_in, r_w, data_in, output data_out, ready, best_level, best_addr);
endinterface

// File: rtl/score_ram.sv
// score_ram: per-user level RAM with post-reset clear sweep; best-level tracker enabled by SCORE_RAM_BEST_EN.
module score_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  score_ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, next_state;
  logic [AW-1:0] clr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic in_range, wr, last;
  logic [AW-1:0] idx;
  always_comb begin
    in_range = {24'd0, bus.address_in} < 32'(DEPTH);
    idx = bus.address_in[AW-1:0];
    last = clr_ptr == AW'(DEPTH - 1);
    wr = state == RUN && bus.r_w && in_range;
    next_state = state == CLEAR && last ? RUN : state;
  end
  always_ff @(posedge clk)
    if (reset) state <= CLEAR;
    else state <= next_state;
  assign bus.ready = state == RUN;
  always_ff @(posedge clk)
    if (reset) clr_ptr <= '0;
    else if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
  // Memory has no reset: the sweep zeroes every entry before RUN is reachable.
  always_ff @(posedge clk)
    if (!reset && state == CLEAR) mem[clr_ptr] <= '0;
    else if (!reset && wr) mem[idx] <= bus.data_in;
  always_ff @(posedge clk)
    if (reset) bus.data_out <= '0;
    else bus.data_out <= state == RUN && in_range ? (bus.r_w ? bus.data_in : mem[idx]) : '0;
`ifdef SCORE_RAM_BEST_EN
  always_ff @(posedge clk)
    if (reset) begin
      bus.best_level <= '0;
      bus.best_addr <= '0;
    end else if (wr && bus.data_in > bus.best_level) begin
      bus.best_level <= bus.data_in;
      bus.best_addr <= bus.address_in;
    end
`else
  assign bus.best_level = '0;
  assign bus.best_addr = '0;
`endif
endmodule

// File: tb/tb_score_ram.sv
// tb_score_ram: directed plus random stimulus against an array-based reference model of score_ram.
module tb_score_ram;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic reset = 1;
  int checks = 0, errors = 0;
  int cnt = 0;
  logic [7:0] m [DEPTH];
  logic [7:0] exp_out = 0, best = 0, baddr = 0;
  score_ram_if #(.WIDTH(8)) bus ();
  score_ram #(.DEPTH(DEPTH), .WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic r, input int a, input logic w, input logic [7:0] d);
    @(negedge clk);
    reset = r;
    bus.address_in = 8'(a);
    bus.r_w = w;
    bus.data_in = d;
    @(posedge clk);
    if (r) begin
      cnt = 0; exp_out = 0; best = 0; baddr = 0;
      foreach (m[i]) m[i] = 0;
    end else if (cnt < DEPTH) begin
      cnt++; exp_out = 0;
    end else if (a >= DEPTH) exp_out = 0;
    else if (w) begin
      m[a] = d; exp_out = d;
      if (d > best) begin best = d; baddr = 8'(a); end
    end else exp_out = m[a];
    #1;
    chk("data_out", 32'(bus.data_out), 32'(exp_out));
    chk("ready", 32'(bus.ready), 32'(cnt >= DEPTH));
`ifdef SCORE_RAM_BEST_EN
    chk("best_level", 32'(bus.best_level), 32'(best));
    chk("best_addr", 32'(bus.best_addr), 32'(baddr));
`else
    chk("best_level", 32'(bus.best_level), 0);
    chk("best_addr", 32'(bus.best_addr), 0);
`endif
  endtask
  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) cyc(0, i, 0, 0);
  endtask
  task automatic sweep();
    cyc(0, 4, 1, 8'h55);
    for (int i = 1; i < DEPTH; i++) cyc(0, i, 1, 8'hAA);
  endtask
  initial begin
    cyc(1, 0, 0, 0);
    sweep();
    read_all();
    cyc(0, 1, 1, 8'h03);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 20, 1, 8'h07);
    cyc(0, 20, 0, 0);
    read_all();
    cyc(0, 2, 1, 8'h05);
    cyc(0, 3, 1, 8'h09);
    cyc(0, 0, 1, 8'h09);
    cyc(0, 3, 1, 8'h04);
    read_all();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, i, 1, 8'h11);
    cyc(1, 0, 0, 0);
    sweep();
    read_all();
    cyc(0, 5, 1, 8'hC8);
    cyc(0, 9, 1, 8'h7F);
    cyc(1, 5, 0, 0);
    sweep();
    read_all();
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) == 0, int'($urandom_range(0, 31)), 1'($urandom), 8'($urandom));
    read_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
